// File: rtl/load_weight_multi_pkg.sv
// Shared state type and sizing/lane helpers for the multi-channel kernel weight loader.
package load_weight_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        DRAIN  = 2'd2,
        COMMIT = 2'd3
    } lw_state_t;

    // Widest BRAM word lane_extract can address.
    localparam int MAX_BRAM_WIDTH = 1024;

    function automatic int calc_kk(input int k);
        return k * k;
    endfunction

    function automatic int calc_lane_bits(input int bram_width);
        return $clog2(bram_width / 8);
    endfunction

    function automatic int calc_tap_idx_w(input int kk);
        return (kk <= 1) ? 1 : $clog2(kk);
    endfunction

    function automatic logic [7:0] lane_extract(input logic [MAX_BRAM_WIDTH-1:0] word,
                                                input int lane);
        return word[lane*8 +: 8];
    endfunction

endpackage

// File: rtl/load_weight_multi_if.sv
// Read-only weight BRAM port bundle; all channels share one byte address.
interface load_weight_multi_if #(
    parameter int NUM_CH        = 4,
    parameter int BRAM_WIDTH    = 32,
    parameter int BRAM_ADDR_BIT = 32
);
    logic                         BRAM_clk;
    logic                         BRAM_en;
    logic                         BRAM_rst;
    logic [BRAM_WIDTH-1:0]        BRAM_din;
    logic [BRAM_WIDTH/8-1:0]      BRAM_wen;
    logic [BRAM_ADDR_BIT-1:0]     BRAM_addr;
    logic [NUM_CH*BRAM_WIDTH-1:0] BRAM_dout;

    modport master (
        output BRAM_clk, BRAM_en, BRAM_rst, BRAM_din, BRAM_wen, BRAM_addr,
        input  BRAM_dout
    );

    modport slave (
        input  BRAM_clk, BRAM_en, BRAM_rst, BRAM_din, BRAM_wen, BRAM_addr,
        output BRAM_dout
    );
endinterface

// File: rtl/load_weight_multi_weight_bank.sv
// Per-channel shadow/active kernel registers; a commit coinciding with a write folds that byte in.
module weight_bank #(
    parameter int KK        = 9,
    parameter int TAP_IDX_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [TAP_IDX_W-1:0] tap,
    input  logic [7:0]           wr_byte,
    input  logic                 commit,
    input  logic                 clear,
    output logic [KK*8-1:0]      weights
);
    logic [7:0] shadow_q  [KK];
    logic [7:0] shadow_nx [KK];
    logic [7:0] active_q  [KK];

    always_comb begin
        for (int t = 0; t < KK; t++) begin
            shadow_nx[t] = shadow_q[t];
            if (wr_en && (tap == TAP_IDX_W'(t))) shadow_nx[t] = wr_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int t = 0; t < KK; t++) begin
                shadow_q[t] <= '0;
                active_q[t] <= '0;
            end
        end else begin
            for (int t = 0; t < KK; t++) begin
                shadow_q[t] <= clear ? 8'h00 : shadow_nx[t];
                if (commit) active_q[t] <= shadow_nx[t];
            end
        end
    end

    // Tap 0 lands in the most significant byte.
    for (genvar t = 0; t < KK; t++) begin : g_tap
        assign weights[(KK-1-t)*8 +: 8] = active_q[t];
    end
endmodule

// File: rtl/load_weight_multi.sv
// Double-buffered KxK kernel loader for NUM_CH weight BRAMs sharing one byte address.
// LOAD_WEIGHT_COMMIT_HS_EN adds commit_ack and a COMMIT hold state before the bank swap.
//
// state  | meaning
// IDLE   | waiting for load_start; addr_rst clears the read pointer
// FETCH  | issuing one shared byte address per cycle, KK in total
// DRAIN  | waiting for the last read data, then commit (or hold)
// COMMIT | shadow complete, waiting for commit_ack (handshake build only)
module load_weight_multi
    import load_weight_pkg::*;
#(
    parameter int NUM_CH        = 4,
    parameter int K             = 3,
    parameter int WEIGHT_WIDTH  = 8,
    parameter int BRAM_WIDTH    = 32,
    parameter int BRAM_ADDR_BIT = 32,
    parameter int BRAM_LATENCY  = 1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                load_start,
    input  logic                                addr_rst,
    input  logic [BRAM_ADDR_BIT-1:0]            weight_size,
`ifdef LOAD_WEIGHT_COMMIT_HS_EN
    input  logic                                commit_ack,
`endif
    output logic                                busy,
    output logic                                load_end,
    output logic                                weight_end,
    output logic [NUM_CH*K*K*WEIGHT_WIDTH-1:0]  weight_out,
    load_weight_multi_if.master                 bram
);
    localparam int KK        = calc_kk(K);
    localparam int LANE_BITS = calc_lane_bits(BRAM_WIDTH);
    localparam int TAP_IDX_W = calc_tap_idx_w(KK);
    localparam int LANE_W    = (LANE_BITS > 0) ? LANE_BITS : 1;
    localparam logic [TAP_IDX_W-1:0] LAST_TAP = TAP_IDX_W'(KK - 1);

    lw_state_t state_q, state_d;
    logic [BRAM_ADDR_BIT-1:0] ptr_q, addr_q, size_m1;
    logic                     wrap_q;
    logic [TAP_IDX_W-1:0]     tap_cnt_q, addr_tap_q;
    logic                     addr_vld_q;
    logic [LANE_W-1:0]        addr_lane;
    logic [BRAM_LATENCY-1:0]  pipe_vld_q;
    logic [TAP_IDX_W-1:0]     pipe_tap_q  [BRAM_LATENCY];
    logic [LANE_W-1:0]        pipe_lane_q [BRAM_LATENCY];
    logic issue, abort, commit, cap_en, cap_last;
    logic load_end_q, weight_end_q;

    assign size_m1  = weight_size - BRAM_ADDR_BIT'(1);
    assign cap_en   = pipe_vld_q[BRAM_LATENCY-1] && !abort;
    assign cap_last = pipe_vld_q[BRAM_LATENCY-1] && (pipe_tap_q[BRAM_LATENCY-1] == LAST_TAP);

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        abort   = 1'b0;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!addr_rst && load_start) begin
                    issue   = 1'b1;
                    state_d = (LAST_TAP == '0) ? DRAIN : FETCH;
                end
            end
            FETCH: begin
                if (addr_rst) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end else begin
                    issue = 1'b1;
                    if (tap_cnt_q == LAST_TAP) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (addr_rst) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end else if (cap_last) begin
`ifdef LOAD_WEIGHT_COMMIT_HS_EN
                    state_d = COMMIT;
`else
                    commit  = 1'b1;
                    state_d = IDLE;
`endif
                end
            end
`ifdef LOAD_WEIGHT_COMMIT_HS_EN
            COMMIT: begin
                if (addr_rst) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end else if (commit_ack) begin
                    commit  = 1'b1;
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    if (LANE_BITS > 0) begin : g_lane
        assign addr_lane = addr_q[LANE_W-1:0];
    end else begin : g_nolane
        assign addr_lane = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q        <= '0;
            addr_q       <= '0;
            wrap_q       <= 1'b0;
            tap_cnt_q    <= '0;
            addr_vld_q   <= 1'b0;
            addr_tap_q   <= '0;
            pipe_vld_q   <= '0;
            load_end_q   <= 1'b0;
            weight_end_q <= 1'b0;
            for (int k = 0; k < BRAM_LATENCY; k++) begin
                pipe_tap_q[k]  <= '0;
                pipe_lane_q[k] <= '0;
            end
        end else begin
            if (addr_rst) begin
                ptr_q     <= '0;
                wrap_q    <= 1'b0;
                tap_cnt_q <= '0;
            end else if (issue) begin
                addr_q    <= ptr_q;
                tap_cnt_q <= (tap_cnt_q == LAST_TAP) ? '0 : tap_cnt_q + TAP_IDX_W'(1);
                // Wrap may land mid-kernel; the flag is reported at the next commit.
                if (ptr_q == size_m1) begin
                    ptr_q  <= '0;
                    wrap_q <= 1'b1;
                end else begin
                    ptr_q <= ptr_q + BRAM_ADDR_BIT'(1);
                end
            end
            if (commit) wrap_q <= 1'b0;

            addr_vld_q     <= issue;
            addr_tap_q     <= tap_cnt_q;
            pipe_vld_q[0]  <= addr_vld_q && !abort;
            pipe_tap_q[0]  <= addr_tap_q;
            pipe_lane_q[0] <= addr_lane;
            for (int k = 1; k < BRAM_LATENCY; k++) begin
                pipe_vld_q[k]  <= pipe_vld_q[k-1] && !abort;
                pipe_tap_q[k]  <= pipe_tap_q[k-1];
                pipe_lane_q[k] <= pipe_lane_q[k-1];
            end

            load_end_q   <= commit;
            weight_end_q <= commit && wrap_q;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [WEIGHT_WIDTH-1:0] cap_byte;
        assign cap_byte = lane_extract(MAX_BRAM_WIDTH'(bram.BRAM_dout[c*BRAM_WIDTH +: BRAM_WIDTH]),
                                       int'(pipe_lane_q[BRAM_LATENCY-1]));
        weight_bank #(.KK(KK), .TAP_IDX_W(TAP_IDX_W)) u_bank (
            .clk     (clk),
            .rst_n   (rst_n),
            .wr_en   (cap_en),
            .tap     (pipe_tap_q[BRAM_LATENCY-1]),
            .wr_byte (cap_byte),
            .commit  (commit),
            .clear   (abort),
            .weights (weight_out[c*KK*WEIGHT_WIDTH +: KK*WEIGHT_WIDTH])
        );
    end

    assign busy            = (state_q != IDLE);
    assign load_end        = load_end_q;
    assign weight_end      = weight_end_q;
    assign bram.BRAM_clk   = clk;
    assign bram.BRAM_en    = 1'b1;
    assign bram.BRAM_rst   = 1'b0;
    assign bram.BRAM_din   = '0;
    assign bram.BRAM_wen   = '0;
    assign bram.BRAM_addr  = addr_q;
endmodule

// File: tb/tb_load_weight_multi.sv
// Scoreboard bench: two loader configurations (4ch/3x3/lat1 and 2ch/5x5/lat3) against BRAM models.
`timescale 1ns/1ps
module tb_load_weight_multi;

`ifdef LOAD_WEIGHT_COMMIT_HS_EN
    localparam int HS_EXTRA = 1;
`else
    localparam int HS_EXTRA = 0;
`endif
    localparam int A_KK = 9;
    localparam int B_KK = 25;
    localparam int A_DONE = A_KK + 1 + 1 + HS_EXTRA;  // load_start cycle -> load_end cycle
    localparam int B_DONE = B_KK + 3 + 1 + HS_EXTRA;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    logic        ls_a = 1'b0, ar_a = 1'b0, ack_a = 1'b1;
    logic        ls_b = 1'b0, ar_b = 1'b0, ack_b = 1'b1;
    logic [31:0] ws_a = 32'd18, ws_b = 32'd100;
    logic        busy_a, le_a, we_a, busy_b, le_b, we_b;
    logic [4*A_KK*8-1:0] wo_a;
    logic [2*B_KK*8-1:0] wo_b;

    load_weight_multi_if #(.NUM_CH(4), .BRAM_WIDTH(32), .BRAM_ADDR_BIT(32)) bus_a ();
    load_weight_multi_if #(.NUM_CH(2), .BRAM_WIDTH(32), .BRAM_ADDR_BIT(32)) bus_b ();

    load_weight_multi #(.NUM_CH(4), .K(3), .WEIGHT_WIDTH(8), .BRAM_WIDTH(32),
                        .BRAM_ADDR_BIT(32), .BRAM_LATENCY(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .load_start(ls_a), .addr_rst(ar_a), .weight_size(ws_a),
`ifdef LOAD_WEIGHT_COMMIT_HS_EN
        .commit_ack(ack_a),
`endif
        .busy(busy_a), .load_end(le_a), .weight_end(we_a), .weight_out(wo_a), .bram(bus_a));

    load_weight_multi #(.NUM_CH(2), .K(5), .WEIGHT_WIDTH(8), .BRAM_WIDTH(32),
                        .BRAM_ADDR_BIT(32), .BRAM_LATENCY(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .load_start(ls_b), .addr_rst(ar_b), .weight_size(ws_b),
`ifdef LOAD_WEIGHT_COMMIT_HS_EN
        .commit_ack(ack_b),
`endif
        .busy(busy_b), .load_end(le_b), .weight_end(we_b), .weight_out(wo_b), .bram(bus_b));

    // BRAM c holds byte value 16*c + a at byte address a.
    function automatic logic [31:0] bram_word(input int c, input logic [31:0] a);
        logic [31:0] w;
        int base;
        base = int'({a[31:2], 2'b00});
        for (int j = 0; j < 4; j++) w[j*8 +: 8] = 8'(16*c + base + j);
        return w;
    endfunction

    logic [31:0] a_q1;
    logic [31:0] b_q [3];
    always @(posedge clk) begin
        a_q1   <= bus_a.BRAM_addr;
        b_q[0] <= bus_b.BRAM_addr;
        b_q[1] <= b_q[0];
        b_q[2] <= b_q[1];
    end
    always_comb begin
        bus_a.BRAM_dout = '0;
        for (int c = 0; c < 4; c++) bus_a.BRAM_dout[c*32 +: 32] = bram_word(c, a_q1);
    end
    always_comb begin
        bus_b.BRAM_dout = '0;
        for (int c = 0; c < 2; c++) bus_b.BRAM_dout[c*32 +: 32] = bram_word(c, b_q[2]);
    end

    // Expected kernel for addresses start, start+1, ... taken modulo size.
    function automatic logic [511:0] kern(input int nch, input int kk, input int start, input int size);
        logic [511:0] r;
        int a;
        r = '0;
        for (int c = 0; c < nch; c++)
            for (int i = 0; i < kk; i++) begin
                a = (start + i) % size;
                r[c*kk*8 + (kk-1-i)*8 +: 8] = 8'(16*c + a);
            end
        return r;
    endfunction

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [511:0] w;
        logic         we;
        int           due;
    } exp_t;
    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;

    task automatic push_a(input int start, input int size, input logic we, input int due);
        qa.push_back('{kern(4, A_KK, start, size), we, due});
    endtask
    task automatic push_b(input int start, input int size, input logic we, input int due);
        qb.push_back('{kern(2, B_KK, start, size), we, due});
    endtask

    // Monitor: pops the scoreboard whenever a DUT presents load_end.
    always @(negedge clk) begin
        if (rst_n) begin
            if (le_a) begin
                if (qa.size() == 0) check("a_unexpected_load_end", 512'(le_a), 512'(0));
                else begin
                    ea = qa.pop_front();
                    check("a_weight_out", 512'(wo_a), ea.w);
                    check("a_weight_end", 512'(we_a), 512'(ea.we));
                    check("a_load_end_cycle", 512'(cyc), 512'(ea.due));
                end
            end else begin
                if (we_a) check("a_weight_end_without_load_end", 512'(we_a), 512'(0));
                if (qa.size() > 0 && cyc > qa[0].due) begin
                    check("a_load_end_missing", 512'(0), 512'(1));
                    ea = qa.pop_front();
                end
            end
            if (le_b) begin
                if (qb.size() == 0) check("b_unexpected_load_end", 512'(le_b), 512'(0));
                else begin
                    eb = qb.pop_front();
                    check("b_weight_out", 512'(wo_b), eb.w);
                    check("b_weight_end", 512'(we_b), 512'(eb.we));
                    check("b_load_end_cycle", 512'(cyc), 512'(eb.due));
                end
            end else begin
                if (we_b) check("b_weight_end_without_load_end", 512'(we_b), 512'(0));
                if (qb.size() > 0 && cyc > qb[0].due) begin
                    check("b_load_end_missing", 512'(0), 512'(1));
                    eb = qb.pop_front();
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] prev_a;

        tick(3);
        check("rst_busy_a", 512'(busy_a), 512'(0));
        check("rst_load_end_a", 512'(le_a), 512'(0));
        check("rst_weight_end_a", 512'(we_a), 512'(0));
        check("rst_weight_out_a", 512'(wo_a), 512'(0));
        check("rst_weight_out_b", 512'(wo_b), 512'(0));
        check("rst_bram_addr_a", 512'(bus_a.BRAM_addr), 512'(0));
        check("rst_bram_en_a", 512'(bus_a.BRAM_en), 512'(1));
        check("rst_bram_rst_a", 512'(bus_a.BRAM_rst), 512'(0));
        check("rst_bram_wen_a", 512'(bus_a.BRAM_wen), 512'(0));
        check("rst_bram_din_a", 512'(bus_a.BRAM_din), 512'(0));
        rst_n = 1'b1;
        tick(2);

        // Load 1: addresses 0..8, load_start during busy is ignored.
        ls_a = 1'b1; push_a(0, 18, 1'b0, cyc + A_DONE);
        tick(1); ls_a = 1'b1;
        check("a_busy_after_start", 512'(busy_a), 512'(1));
        check("a_first_addr", 512'(bus_a.BRAM_addr), 512'(0));
        tick(1); ls_a = 1'b0;
        check("a_second_addr", 512'(bus_a.BRAM_addr), 512'(1));
        tick(A_DONE - 2);
        // Back-to-back: 9..17 wraps the 18-byte region.
        ls_a = 1'b1; push_a(9, 18, 1'b1, cyc + A_DONE);
        tick(1); ls_a = 1'b0;
        check("a_load2_first_addr", 512'(bus_a.BRAM_addr), 512'(9));
        tick(A_DONE - 1);
        ls_a = 1'b1; push_a(0, 18, 1'b0, cyc + A_DONE);
        tick(1); ls_a = 1'b0;
        check("a_load3_first_addr", 512'(bus_a.BRAM_addr), 512'(0));
        tick(A_DONE - 1);
        tick(2);

        // 12-byte region: second kernel wraps mid-kernel.
        ar_a = 1'b1; ws_a = 32'd12;
        tick(1); ar_a = 1'b0;
        check("a_busy_after_idle_addr_rst", 512'(busy_a), 512'(0));
        ls_a = 1'b1; push_a(0, 12, 1'b0, cyc + A_DONE);
        tick(1); ls_a = 1'b0;
        tick(A_DONE - 1);
        ls_a = 1'b1; push_a(9, 12, 1'b1, cyc + A_DONE);
        tick(1); ls_a = 1'b0;
        tick(A_DONE - 1);
        tick(2);
        prev_a = kern(4, A_KK, 9, 12);

        // Abort at FETCH cycle 4: no load_end, active bank kept.
        ls_a = 1'b1;
        tick(1); ls_a = 1'b0;
        tick(3); ar_a = 1'b1;
        tick(1); ar_a = 1'b0;
        check("a_abort_busy", 512'(busy_a), 512'(0));
        tick(A_DONE + 2);
        check("a_abort_weight_out", 512'(wo_a), prev_a);
        // load_start together with addr_rst is dropped.
        ls_a = 1'b1; ar_a = 1'b1;
        tick(1); ls_a = 1'b0; ar_a = 1'b0;
        check("a_start_with_addr_rst_busy", 512'(busy_a), 512'(0));
        tick(2);
        ls_a = 1'b1; push_a(0, 12, 1'b0, cyc + A_DONE);
        tick(1); ls_a = 1'b0;
        check("a_after_abort_first_addr", 512'(bus_a.BRAM_addr), 512'(0));
        tick(A_DONE - 1);
        tick(2);
        prev_a = kern(4, A_KK, 0, 12);

        // 5x5 kernel with three-cycle BRAM latency.
        ls_b = 1'b1; push_b(0, 100, 1'b0, cyc + B_DONE);
        tick(1); ls_b = 1'b0;
        tick(B_DONE - 1);
        ls_b = 1'b1; push_b(25, 100, 1'b0, cyc + B_DONE);
        tick(1); ls_b = 1'b0;
        tick(B_DONE - 1);
        tick(2);

`ifdef LOAD_WEIGHT_COMMIT_HS_EN
        // Hold in COMMIT without ack; weights stay, extra load_start ignored.
        ack_a = 1'b0;
        ls_a = 1'b1;
        tick(1); ls_a = 1'b0;
        tick(A_KK + 10);
        ls_a = 1'b1;
        tick(1); ls_a = 1'b0;
        tick(10);
        check("a_hs_busy_wait", 512'(busy_a), 512'(1));
        check("a_hs_weight_out_wait", 512'(wo_a), prev_a);
        ack_a = 1'b1; push_a(9, 12, 1'b1, cyc + 1);
        tick(1);
        tick(2);
        check("a_hs_idle_after_commit", 512'(busy_a), 512'(0));
`endif

        // Reset mid-load clears the active bank.
        ls_a = 1'b1;
        tick(1); ls_a = 1'b0;
        tick(3); rst_n = 1'b0;
        tick(1); rst_n = 1'b1;
        check("a_midload_rst_weight_out", 512'(wo_a), 512'(0));
        check("a_midload_rst_busy", 512'(busy_a), 512'(0));
        check("b_midload_rst_weight_out", 512'(wo_b), 512'(0));
        tick(A_DONE + 2);
        check("a_post_rst_load_end", 512'(le_a), 512'(0));

        tick(3);
        check("a_scoreboard_drained", 512'(qa.size()), 512'(0));
        check("b_scoreboard_drained", 512'(qb.size()), 512'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/load_weight_multi.md
Name: load_weight_multi

Overview:
- Parametrised successor of the 4-channel 3x3 weight loader.
- Fetches one KxK kernel per channel from NUM_CH read-only weight BRAMs. The BRAMs share one byte address.
- Assembles each kernel in shadow registers, then commits all channels atomically to the active bank. The active bank feeds the conv PE array.
- The PEs see stable weights while the next kernel loads (double buffering). BRAM read latency is configurable.

Parameters:
- NUM_CH, 4, number of weight channels/BRAMs (1..16)
- K, 3, kernel side; taps KK = K*K (1..7)
- WEIGHT_WIDTH, 8, bits per weight; fixed at 8 (byte-lane extraction)
- BRAM_WIDTH, 32, BRAM data width; power of 2, >= 8
- BRAM_ADDR_BIT, 32, byte-address width
- BRAM_LATENCY, 1, cycles from address to dout valid (1..3)

Ports:
- clk  in  1  clock; also driven out as BRAM_clk
- rst_n  in  1  reset, synchronous, active-low
- load_start  in  1  request one kernel load; sampled only in IDLE
- addr_rst  in  1  return read pointer to 0
- weight_size  in  BRAM_ADDR_BIT  bytes per channel; 0 means 2^BRAM_ADDR_BIT
- busy  out  1  high outside IDLE
- load_end  out  1  one-cycle pulse: new weights committed
- weight_end  out  1  one-cycle pulse with load_end when this load wrapped the pointer
- weight_out  out  NUM_CH*KK*WEIGHT_WIDTH  active bank
  - channel c occupies slice c (channel 0 = LSBs)
  - within a slice, tap 0 is MSB
- BRAM_clk/BRAM_en/BRAM_rst  out  1 each  = clk / 1 / 0
- BRAM_din  out  BRAM_WIDTH  = 0
- BRAM_wen  out  BRAM_WIDTH/8  = 0
- BRAM_addr  out  BRAM_ADDR_BIT  shared registered byte address
- BRAM_dout  in  NUM_CH*BRAM_WIDTH  channel c at slice c

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE; pointer, BRAM_addr, shadow and active banks = 0; busy/load_end/weight_end = 0.
- States: IDLE, FETCH, DRAIN (COMMIT only with the optional feature).
- IDLE -> FETCH: load_start=1 at edge T.
  - BRAM_addr presents pointer+i during cycle T+1+i, i = 0..KK-1.
- FETCH -> DRAIN after the KK-th address.
- DRAIN: waits BRAM_LATENCY cycles for the last data, then commits.
- Capture pipeline:
  - A valid/tap-index/lane shift register of depth BRAM_LATENCY.
  - lane = addr[log2(BRAM_WIDTH/8)-1:0].
  - Shadow tap i of channel c <= BRAM_dout slice c, bits [lane*8 +: 8].
- Commit:
  - Shadow -> active on the edge after the last capture.
  - load_end=1 and the new weight_out are visible in the same cycle, T+KK+BRAM_LATENCY+1.
  - Example: K=3, LAT=1 gives cycle T+11. State is IDLE in that cycle.
- Pointer:
  - Increments per issued address.
  - At pointer == weight_size-1 the next value is 0, including mid-kernel, and a wrap flag is set.
  - weight_end pulses with load_end iff the flag is set; the flag clears at commit.
- load_start while busy: ignored (not queued).
- load_start in the load_end cycle: accepted as a normal IDLE request; back-to-back loads are allowed.
- addr_rst in IDLE: pointer <= 0 next edge.
- addr_rst while busy:
  - Aborts the load and returns to IDLE next edge.
  - Shadow and capture pipeline are discarded; active bank is unchanged.
  - No load_end/weight_end; pointer <= 0.
- load_start and addr_rst in the same IDLE cycle: addr_rst wins; load_start is dropped.
- rst_n mid-load: full reset; active bank cleared.
- weight_out changes only at commit or reset.

Optional Feature:
- Macro LOAD_WEIGHT_COMMIT_HS_EN.
- Defined:
  - Adds input commit_ack (1 bit) and state COMMIT.
  - After the last capture, the FSM sits in COMMIT (busy=1).
  - Shadow -> active happens on the first edge with commit_ack=1; load_end/weight_end pulse in the following cycle.
  - addr_rst in COMMIT aborts as above.
- Undefined:
  - No commit_ack port and no COMMIT state.
  - Commit is unconditional, timed as in Behaviour.

Decomposition:
- Package load_weight_pkg holds:
  - state enum (IDLE/FETCH/DRAIN/COMMIT)
  - localparams KK, LANE_BITS = log2(BRAM_WIDTH/8), TAP_IDX_W = clog2(KK)
  - function lane_extract(word, lane)
- One natural sub-module: weight_bank. One per channel, generate-instantiated.
  - Holds the shadow and active KK x 8 registers.
  - Inputs: wr_en, tap index, byte, commit, clear.
- The top holds the FSM, pointer/wrap logic and capture pipeline.

Test Plan:
- NUM_CH=4, K=3, LAT=1, weight_size=18; BRAM c byte a = 16*c+a; pulse load_start at T -> addresses 0..8 on T+1..T+9; load_end at T+11; ch0 slice = 0x00..0x08 (tap0 MSB); ch3 = 0x30..0x38; weight_end=0.
- Second load_start in the load_end cycle -> addresses 9..17; commit 11 cycles later; weight_end=1; pointer back to 0; third load reads 0..8.
- weight_size=12, two loads -> second load fetches 9,10,11,0,1,..,5; weight_end=1 on the second load_end.
- addr_rst at FETCH cycle 4 -> IDLE next edge; no load_end; weight_out equals the previous kernel; next load starts at address 0.
- LAT=3, K=5, NUM_CH=2 -> load_end exactly 25+3+1 cycles after load_start; all 25 taps match their byte lanes for addresses 0..24.
- With LOAD_WEIGHT_COMMIT_HS_EN, hold commit_ack=0 for 20 cycles -> busy=1 and weight_out unchanged; raise commit_ack -> new weights plus load_end one cycle later; load_start during the wait is ignored.
